// File: rtl/memory_game_pkg.sv
// ============================================================================
// memory_game_pkg : shared note encodings, LFSR mask and generator states
// Rev 1.0
// ============================================================================
`default_nettype none

package memory_game_pkg;

  localparam int NOTE_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_0 = 4'b0001;
  localparam logic [NOTE_W-1:0] NOTE_1 = 4'b0010;
  localparam logic [NOTE_W-1:0] NOTE_2 = 4'b0100;
  localparam logic [NOTE_W-1:0] NOTE_3 = 4'b1000;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  // An immediate repeat is broken by rotating the candidate one place left.
  function automatic logic [NOTE_W-1:0] pick_note(input logic [1:0]        sel,
                                                  input logic [NOTE_W-1:0] prev,
                                                  input logic              first);
    logic [NOTE_W-1:0] cand;
    case (sel)
      2'd0:    cand = NOTE_0;
      2'd1:    cand = NOTE_1;
      2'd2:    cand = NOTE_2;
      default: cand = NOTE_3;
    endcase
    if (!first && (cand == prev))
      cand = {cand[NOTE_W-2:0], cand[NOTE_W-1]};
    return cand;
  endfunction

endpackage

`default_nettype wire

// File: rtl/level_generator_if.sv
// ============================================================================
// level_generator_if : command and level-data bundle between control and generator
// Rev 1.0
// ============================================================================
`default_nettype none

interface level_generator_if #(
  parameter int MAX_NOTES = 4,
  parameter int LEN_W     = 4
);

  logic                   new_game;
  logic                   level_won;
  logic [4*MAX_NOTES-1:0] level_data;
  logic [LEN_W-1:0]       level_length;
  logic                   level_valid;
  logic                   game_complete;

  modport master (
    output new_game,
    output level_won,
    input  level_data,
    input  level_length,
    input  level_valid,
    input  game_complete
  );

  modport slave (
    input  new_game,
    input  level_won,
    output level_data,
    output level_length,
    output level_valid,
    output game_complete
  );

endinterface

`default_nettype wire

// File: rtl/note_lfsr.sv
// ============================================================================
// note_lfsr : free-running 16-bit Galois LFSR, loaded with seed on reset
// Rev 1.0
// ============================================================================
`default_nettype none

module note_lfsr
  import memory_game_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (!resetn)
      out <= seed;
    else if (out[0])
      out <= (out >> 1) ^ LFSR_MASK;
    else
      out <= out >> 1;
  end

endmodule

`default_nettype wire

// File: rtl/level_generator.sv
// ============================================================================
// level_generator : builds the growing one-hot note sequence for game_core
// Rev 1.0
// ============================================================================
`default_nettype none

module level_generator
  import memory_game_pkg::*;
#(
  parameter int          MAX_NOTES = 4,
  parameter int          START_LEN = 1,
  parameter int          LEN_W     = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             resetn,
  level_generator_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_NOTES);
  localparam logic [LEN_W-1:0] START_L   = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  gen_state_t        state;
  logic [LEN_W-1:0]  target;
  logic [NOTE_W-1:0] last_note;
  logic [15:0]       lfsr;
  logic [1:0]        lfsr_low;
  logic [13:0]       lfsr_unused;
  logic [NOTE_W-1:0] next_note;
  logic [LEN_W-1:0]  len_inc;

  note_lfsr u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .seed   (SEED),
    .out    (lfsr)
  );

  assign {lfsr_unused, lfsr_low} = lfsr;
  assign len_inc   = bus.level_length + ONE_L;
  assign next_note = pick_note(lfsr_low, last_note, bus.level_length == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= IDLE;
      target            <= '0;
      last_note         <= '0;
      bus.level_data    <= '0;
      bus.level_length  <= '0;
      bus.level_valid   <= 1'b0;
      bus.game_complete <= 1'b0;
    end else if (bus.new_game) begin
      // Restart wins over everything, including a build in progress.
      state             <= GEN;
      target            <= START_L;
      bus.level_data    <= '0;
      bus.level_length  <= '0;
      bus.level_valid   <= 1'b0;
      bus.game_complete <= 1'b0;
    end else begin
      case (state)
        GEN: begin
          if (bus.level_length < MAX_LEN) begin
            for (int i = 0; i < MAX_NOTES; i++) begin
              if (LEN_W'(i) == bus.level_length)
                bus.level_data[NOTE_W*(MAX_NOTES-1-i) +: NOTE_W] <= next_note;
            end
            bus.level_length <= len_inc;
            last_note        <= next_note;
            if (len_inc == target) begin
              state           <= READY;
              bus.level_valid <= 1'b1;
            end
          end
        end
        READY: begin
          if (bus.level_won) begin
            bus.level_valid <= 1'b0;
            if (bus.level_length < MAX_LEN) begin
              target <= len_inc;
              state  <= GEN;
            end else begin
              bus.game_complete <= 1'b1;
              state             <= DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_level_generator.sv
// ============================================================================
// tb_level_generator : scoreboard bench for level_generator
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_level_generator;

  localparam int          MAX_NOTES = 4;
  localparam int          LEN_W     = 4;
  localparam logic [15:0] SEED      = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic resetn4;

  level_generator_if #(.MAX_NOTES(MAX_NOTES), .LEN_W(LEN_W)) bus ();
  level_generator_if #(.MAX_NOTES(MAX_NOTES), .LEN_W(LEN_W)) bus4 ();

  level_generator #(.MAX_NOTES(MAX_NOTES), .START_LEN(1), .LEN_W(LEN_W), .SEED(SEED)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  level_generator #(.MAX_NOTES(MAX_NOTES), .START_LEN(4), .LEN_W(LEN_W), .SEED(SEED)) u_dut4 (
    .clk    (clk),
    .resetn (resetn4),
    .bus    (bus4)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  len;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  int          checks = 0;
  int          errors = 0;
  logic        prev_valid = 1'b0;

  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr4;
  logic [15:0] m_data;
  int          m_len;
  logic [3:0]  m_last;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic logic [3:0] note_of(input logic [15:0] l, input bit first, input logic [3:0] last);
    logic [3:0] c;
    c = 4'b0001 << l[1:0];
    if (!first && c == last) c = ((c << 1) | (c >> 3)) & 4'hF;
    return c;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    m_lfsr  <= !resetn  ? SEED : lfsr_step(m_lfsr);
    m_lfsr4 <= !resetn4 ? SEED : lfsr_step(m_lfsr4);
  end

  always @(negedge clk) begin
    if (bus.level_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", sb_q.size(), 1);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("sb_len", bus.level_length, sb_e.len);
        check_val("sb_data", bus.level_data, sb_e.data);
      end
    end
    prev_valid = bus.level_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic append_model(input logic [15:0] l);
    logic [3:0] n;
    n = note_of(l, m_len == 0, m_last);
    m_data[4*(3-m_len) +: 4] = n;
    m_len++;
    m_last = n;
  endtask

  task automatic push_exp();
    exp_t e;
    e.data = m_data;
    e.len  = 4'(m_len);
    sb_q.push_back(e);
  endtask

  task automatic do_new_game(input bit with_won);
    bus.new_game  = 1'b1;
    bus.level_won = with_won;
    tick();
    bus.new_game  = 1'b0;
    bus.level_won = 1'b0;
    check_val("ng_len0", bus.level_length, 0);
    check_val("ng_cplt", bus.game_complete, 0);
    check_val("ng_valid_lo", bus.level_valid, 0);
    m_data = '0;
    m_len  = 0;
    m_last = '0;
    append_model(m_lfsr);
    push_exp();
    tick();
    check_val("ng_valid_hi", bus.level_valid, 1);
  endtask

  task automatic do_won();
    bus.level_won = 1'b1;
    tick();
    bus.level_won = 1'b0;
    check_val("won_valid_lo", bus.level_valid, 0);
    append_model(m_lfsr);
    push_exp();
    tick();
    check_val("won_valid_hi", bus.level_valid, 1);
  endtask

  task automatic do_won_final();
    bus.level_won = 1'b1;
    tick();
    bus.level_won = 1'b0;
    check_val("fin_cplt", bus.game_complete, 1);
    check_val("fin_valid", bus.level_valid, 0);
    check_val("fin_len", bus.level_length, 4);
    check_val("fin_data", bus.level_data, m_data);
    bus.level_won = 1'b1;
    tick();
    bus.level_won = 1'b0;
    tick();
    check_val("done_hold", {bus.game_complete, bus.level_valid, bus.level_length, bus.level_data},
              {1'b1, 1'b0, 4'd4, m_data});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    resetn4        = 1'b0;
    bus.new_game   = 1'b0;
    bus.level_won  = 1'b0;
    bus4.new_game  = 1'b0;
    bus4.level_won = 1'b0;
    m_data = '0;
    m_len  = 0;
    m_last = '0;
    repeat (3) tick();
    resetn  = 1'b1;
    resetn4 = 1'b1;

    for (int i = 0; i < 20; i++) begin
      check_val("idle_zero", {bus.game_complete, bus.level_valid, bus.level_length, bus.level_data}, 0);
      tick();
    end

    // first game: grow to 4, complete, then restart
    do_new_game(1'b0);
    check_val("lvl1_low", bus.level_data[11:0], 0);
    for (int i = 0; i < 3; i++) do_won();
    do_won_final();
    do_new_game(1'b0);

    // simultaneous new_game and level_won at length 2
    do_won();
    do_new_game(1'b1);
    do_won();

    // more games to exercise the repeat filter
    for (int g = 0; g < 6; g++) begin
      do_new_game(1'b0);
      for (int i = 0; i < 3; i++) do_won();
      do_won_final();
    end

    // START_LEN=4 instance: full build, then reset mid-build
    bus4.new_game = 1'b1;
    tick();
    bus4.new_game = 1'b0;
    begin
      logic [15:0] l;
      logic [15:0] d;
      logic [3:0]  last;
      logic [3:0]  n;
      l = m_lfsr4;
      d = '0;
      last = '0;
      for (int k = 0; k < 4; k++) begin
        n = note_of(l, k == 0, last);
        d[4*(3-k) +: 4] = n;
        last = n;
        l = lfsr_step(l);
      end
      repeat (3) tick();
      check_val("s4_valid_early", bus4.level_valid, 0);
      tick();
      check_val("s4_valid", bus4.level_valid, 1);
      check_val("s4_len", bus4.level_length, 4);
      check_val("s4_data", bus4.level_data, d);
    end
    bus4.new_game = 1'b1;
    tick();
    bus4.new_game = 1'b0;
    repeat (2) tick();
    check_val("s4_midbuild_len", bus4.level_length, 2);
    resetn4 = 1'b0;
    tick();
    check_val("s4_rst_outs", {bus4.game_complete, bus4.level_valid, bus4.level_length, bus4.level_data}, 0);
    check_val("s4_rst_lfsr", u_dut4.lfsr, 16'hACE1);
    check_val("s4_rst_state", u_dut4.state, 0);
    resetn4 = 1'b1;
    tick();

    check_val("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
